// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - saturating-counter branch direction predictor table
// Combinational lookup for fetch, single-port training from execute, flop-based for one-cycle flush.
module branch_history_table #(
  parameter int ENTRIES   = 64,
  parameter int CTR_WIDTH = 2,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             pred_taken_o,
  output logic             pred_strong_o,
  input  logic             update_en_i,
  input  logic [IDX_W-1:0] update_idx_i,
  input  logic             update_taken_i,
  input  logic             clear_i
);

  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

  logic [CTR_WIDTH-1:0] ctr_q [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_d [ENTRIES];
  logic [CTR_WIDTH-1:0] lookup_ctr;
  logic [CTR_WIDTH-1:0] update_ctr;

  assign lookup_ctr    = ctr_q[lookup_idx_i];
  assign update_ctr    = ctr_q[update_idx_i];
  assign pred_taken_o  = lookup_ctr[CTR_WIDTH-1];
  assign pred_strong_o = (lookup_ctr == CTR_MAX) || (lookup_ctr == '0);

  // Clear overrides training; reset is applied in the register process.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (clear_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = CTR_INIT;
      end
    end else if (update_en_i) begin
      if (update_taken_i) begin
        if (update_ctr != CTR_MAX) begin
          ctr_d[update_idx_i] = update_ctr + CTR_ONE;
        end
      end else if (update_ctr != '0) begin
        ctr_d[update_idx_i] = update_ctr - CTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

endmodule
